div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Round-robin scheduler that shares one sequential unsigned divider core (divu256-style engine) among NREQ requesters.
- Grants one request at a time and latches its operands.
- Launches the divider by pulsing the divider's active-low reset, waits for completion, divide-by-zero or timeout, then returns the result on a single tagged response channel.
- Sits between compute clients and the single divider instance.

Parameters:
- W, 256, operand/result width; must equal the divider's N.
- NREQ, 4, number of requesters (2..16).
- TO_CYC, W+8, RUN-state cycle limit before a timeout error.
- IDW, $clog2(NREQ), response ID width (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_divd  in  NREQ*W  dividends, requester i at [i*W +: W]
- req_dvsr  in  NREQ*W  divisors, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of the served requester
- rsp_quo  out  W  quotient
- rsp_rem  out  W  remainder
- rsp_dbz  out  1  divisor was zero
- rsp_err  out  1  timeout
- div_rst_n  out  1  divider reset/launch, active-low
- div_divd  out  W  divider dividend (held stable)
- div_dvsr  out  W  divider divisor (held stable)
- div_val  in  W  divider quotient
- div_rem  in  W  divider remainder
- div_dbz  in  1  divider divide-by-zero flag
- div_rdy  in  1  divider data-ready

Behaviour:
- Reset values: state=IDLE, rr pointer=0, req_ready=0, rsp_valid=0, rsp_* =0, div_rst_n=0, div_divd/div_dvsr=0, timeout counter=0.
- FSM states: IDLE, LAUNCH, RUN, RESP.
- IDLE:
  - If any req_valid is set, pick the first valid index at or after the pointer, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle only.
  - Latch divd/dvsr[g] into the div_* registers and g into the id register.
  - Pointer becomes (g+1) mod NREQ; go to LAUNCH.
  - No valid: stay in IDLE.
- LAUNCH: one cycle, div_rst_n=0, counter cleared; go to RUN.
- div_rst_n=1 in RUN and RESP only; it is 0 in IDLE and LAUNCH, so the divider is held in reset when unused.
- RUN: counter increments each cycle. Exit conditions, in priority order:
  - div_dbz=1: capture quo=0, rem=0, dbz=1.
  - div_rdy=1: capture quo=div_val, rem=div_rem.
  - counter reaches TO_CYC-1: err=1, quo=rem=0.
  - On any exit, go to RESP.
- RESP:
  - rsp_valid=1 and all rsp_* held stable until rsp_ready=1.
  - On handshake, go to IDLE; rsp_valid deasserts the next cycle.
  - No new grant is issued in the handshake cycle.
- Latency: grant → LAUNCH 1 cycle → RUN up to W+3 cycles for the divider → RESP. Zero divisor responds on the first RUN cycle.
- Operand stability: div_divd/div_dvsr are only written in the IDLE grant cycle. Requesters may change req_* after their ready cycle.
- Simultaneous requests: exactly one grant per transaction. A continuously asserted requester is served at least once every NREQ transactions.
- A req_valid that drops before grant is simply not served; no state is kept per requester.
- rsp_ready may be held high permanently; throughput is then one transaction per (2 + RUN + 1) cycles.
- Asynchronous reset mid-operation:
  - Immediate return to IDLE; pointer resets to 0.
  - Any in-flight result is discarded; div_rst_n goes low.
- div_rdy/div_dbz outside RUN are ignored.

Optional Feature:
- Macro: DIVARB_DBZ_BYPASS_EN.
- Defined:
  - At grant, a zero divisor is detected.
  - FSM goes IDLE→RESP directly with quo=0, rem=0, dbz=1, err=0, id=g.
  - The divider is never launched (div_rst_n stays 0); latency is 1 cycle after grant.
- Undefined: zero-divisor requests go through LAUNCH/RUN, and dbz comes from div_dbz.

Decomposition:
- Package divarb_pkg:
  - state enum typedef (IDLE, LAUNCH, RUN, RESP).
  - Default W.
  - Timeout default function of W.
- Sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded index; combinational.
- Pointer register and FSM stay in div_arbiter.

Test Plan:
- Single request, divd=100, dvsr=7 on req 2; rsp_ready=1 → rsp_id=2, quo=14, rem=2, dbz=0, err=0. div_rst_n low for exactly 1 cycle before RUN.
- All 4 valid continuously, each with distinct operands → grant order 0,1,2,3,0. Each response matches its own operands.
- dvsr=0 on req 1, macro undefined → rsp_dbz=1, quo=rem=0, response in the first RUN cycle. With macro defined → rsp_valid one cycle after grant and div_rst_n never high.
- rsp_ready held low for 20 cycles in RESP → rsp_* stable and req_ready=0 throughout. Completes on the cycle rsp_ready=1.
- Divider model that never asserts div_rdy → rsp_err=1 after TO_CYC RUN cycles. The next request is served normally.
- rst pulsed low mid-RUN → all outputs return to reset values immediately. Pointer=0, so the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/divarb_pkg.sv
// Shared types and defaults for the divider arbiter slice.
package divarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Operand/result width of the shared divider core.
    localparam int DIVARB_W = 256;

    // RUN-state cycle limit: divider worst case (W+3) plus margin.
    function automatic int divarb_to_cyc(input int w);
        return w + 32'sd8;
    endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Bundle of requester, response and divider-side signals of div_arbiter.
// slave: arbiter view. master: clients plus divider view.
interface div_arbiter_if #(
    parameter int W    = divarb_pkg::DIVARB_W,
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_divd;
    logic [NREQ*W-1:0] req_dvsr;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_quo;
    logic [W-1:0]      rsp_rem;
    logic              rsp_dbz;
    logic              rsp_err;

    logic              div_rst_n;
    logic [W-1:0]      div_divd;
    logic [W-1:0]      div_dvsr;
    logic [W-1:0]      div_val;
    logic [W-1:0]      div_rem;
    logic              div_dbz;
    logic              div_rdy;

    modport slave (
        input  req_valid, req_divd, req_dvsr, rsp_ready,
        input  div_val, div_rem, div_dbz, div_rdy,
        output req_ready, rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_dbz, rsp_err,
        output div_rst_n, div_divd, div_dvsr
    );

    modport master (
        output req_valid, req_divd, req_dvsr, rsp_ready,
        output div_val, div_rem, div_dbz, div_rdy,
        input  req_ready, rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_dbz, rsp_err,
        input  div_rst_n, div_divd, div_dvsr
    );

endinterface

// File: rtl/div_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ. Produces one-hot grant and its encoded index.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic found_s;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end else begin
            s = s;
        end
        return s[IDW-1:0];
    endfunction

    // Scan from the pointer and grant the first valid requester.
    always_comb begin
        gnt     = {NREQ{1'b0}};
        gnt_idx = {IDW{1'b0}};
        found_s = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            if (en && !found_s && req[wrap_idx(ptr, off)]) begin
                gnt[wrap_idx(ptr, off)] = 1'b1;
                gnt_idx                 = wrap_idx(ptr, off);
                found_s                 = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one sequential divider among NREQ clients.
// Optional build macro DIVARB_DBZ_BYPASS_EN: zero divisors are answered
// straight from the grant cycle without launching the divider.
module div_arbiter
    import divarb_pkg::*;
#(
    parameter int W      = DIVARB_W,
    parameter int NREQ   = 4,
    parameter int TO_CYC = divarb_to_cyc(W)
) (
    input  logic         clk,
    input  logic         rst,
    div_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TO_CYC + 1);

    state_t          state_r, state_nxt_s;
    logic [NREQ-1:0] gnt_s;
    logic [IDW-1:0]  gnt_idx_s;
    logic            gnt_any_s;
    logic            arb_en_s;
    logic [W-1:0]    sel_divd_s, sel_dvsr_s;

    logic [IDW-1:0]  ptr_r, id_r;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    div_divd_r, div_dvsr_r;
    logic [W-1:0]    rsp_quo_r, rsp_rem_r;
    logic            rsp_valid_r, rsp_dbz_r, rsp_err_r;
    logic            div_rst_n_r, div_rst_n_nxt_s;

    logic            cap_s;
    logic [W-1:0]    cap_quo_s, cap_rem_s;
    logic            cap_dbz_s, cap_err_s;

    // Grants only in IDLE; gating with rst keeps req_ready low during reset.
    assign arb_en_s = (state_r == ST_IDLE) && rst;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (bus.req_valid),
        .ptr     (ptr_r),
        .en      (arb_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    assign gnt_any_s  = |gnt_s;
    assign sel_divd_s = bus.req_divd[int'(gnt_idx_s)*W +: W];
    assign sel_dvsr_s = bus.req_dvsr[int'(gnt_idx_s)*W +: W];

    // Divider held in reset except while it runs or its result is pending.
    assign div_rst_n_nxt_s = (state_nxt_s == ST_RUN) ||
                             ((state_nxt_s == ST_RESP) && div_rst_n_r);

    // Next-state and result-capture decode.
    always_comb begin
        state_nxt_s = state_r;
        cap_s       = 1'b0;
        cap_quo_s   = {W{1'b0}};
        cap_rem_s   = {W{1'b0}};
        cap_dbz_s   = 1'b0;
        cap_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gnt_any_s) begin
`ifdef DIVARB_DBZ_BYPASS_EN
                    if (sel_dvsr_s == {W{1'b0}}) begin
                        state_nxt_s = ST_RESP;
                        cap_s       = 1'b1;
                        cap_dbz_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_LAUNCH;
                    end
`else
                    state_nxt_s = ST_LAUNCH;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (bus.div_dbz) begin
                    state_nxt_s = ST_RESP;
                    cap_s       = 1'b1;
                    cap_dbz_s   = 1'b1;
                end else if (bus.div_rdy) begin
                    state_nxt_s = ST_RESP;
                    cap_s       = 1'b1;
                    cap_quo_s   = bus.div_val;
                    cap_rem_s   = bus.div_rem;
                end else if (cnt_r == CW'(TO_CYC - 1)) begin
                    state_nxt_s = ST_RESP;
                    cap_s       = 1'b1;
                    cap_err_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant latching, run counter, response registers and divider launch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r       <= {IDW{1'b0}};
            id_r        <= {IDW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            div_divd_r  <= {W{1'b0}};
            div_dvsr_r  <= {W{1'b0}};
            rsp_quo_r   <= {W{1'b0}};
            rsp_rem_r   <= {W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_dbz_r   <= 1'b0;
            rsp_err_r   <= 1'b0;
            div_rst_n_r <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && gnt_any_s) begin
                div_divd_r <= sel_divd_s;
                div_dvsr_r <= sel_dvsr_s;
                id_r       <= gnt_idx_s;
                ptr_r      <= (gnt_idx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : gnt_idx_s + IDW'(1);
            end
            if (state_r == ST_LAUNCH) begin
                cnt_r <= {CW{1'b0}};
            end else if (state_r == ST_RUN) begin
                cnt_r <= cnt_r + CW'(1);
            end
            if (cap_s) begin
                rsp_valid_r <= 1'b1;
                rsp_quo_r   <= cap_quo_s;
                rsp_rem_r   <= cap_rem_s;
                rsp_dbz_r   <= cap_dbz_s;
                rsp_err_r   <= cap_err_s;
            end else if ((state_r == ST_RESP) && bus.rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end
            div_rst_n_r <= div_rst_n_nxt_s;
        end
    end

    assign bus.req_ready = gnt_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = id_r;
    assign bus.rsp_quo   = rsp_quo_r;
    assign bus.rsp_rem   = rsp_rem_r;
    assign bus.rsp_dbz   = rsp_dbz_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.div_rst_n = div_rst_n_r;
    assign bus.div_divd  = div_divd_r;
    assign bus.div_dvsr  = div_dvsr_r;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter with a behavioural divider.
module tb_div_arbiter;

    localparam int W      = 256;
    localparam int NREQ   = 4;
    localparam int TO_CYC = W + 8;
    localparam int LAT    = 5;
`ifdef DIVARB_DBZ_BYPASS_EN
    localparam int DBZ_LAT = 1;
    localparam bit DBZ_HI  = 1'b0;
`else
    localparam int DBZ_LAT = 3;
    localparam bit DBZ_HI  = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   hang = 1'b0;
    int   mcnt = 0;
    int   errors = 0;
    int   checks = 0;

    div_arbiter_if #(.W(W), .NREQ(NREQ)) bus();

    div_arbiter #(.W(W), .NREQ(NREQ), .TO_CYC(TO_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Divider model: result LAT cycles after release, dbz at once, or never when hung.
    always @(posedge clk) begin
        if (!bus.div_rst_n) mcnt <= 0;
        else                mcnt <= mcnt + 1;
    end
    assign bus.div_dbz = bus.div_rst_n && (bus.div_dvsr == '0);
    assign bus.div_rdy = bus.div_rst_n && !hang && (mcnt >= LAT);
    assign bus.div_val = (bus.div_dvsr == '0) ? '1 : bus.div_divd / bus.div_dvsr;
    assign bus.div_rem = (bus.div_dvsr == '0) ? '1 : bus.div_divd % bus.div_dvsr;

    task automatic set_op(input int i, input int d, input int s);
        bus.req_divd[i*W +: W] = W'(d);
        bus.req_dvsr[i*W +: W] = W'(s);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        hang = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_rsp(input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < limit && !ok) begin
            @(negedge clk);
            cyc++;
            if (bus.rsp_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b want 0000", bus.req_ready); end
        checks++; if ({bus.rsp_valid, bus.rsp_dbz, bus.rsp_err, bus.div_rst_n} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", {bus.rsp_valid, bus.rsp_dbz, bus.rsp_err, bus.div_rst_n}); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL rst_id: got %0d want 0", bus.rsp_id); end
        checks++; if ((bus.rsp_quo | bus.rsp_rem | bus.div_divd | bus.div_dvsr) !== '0) begin errors++; $display("FAIL rst_data: got nonzero want 0"); end
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int cyc; bit ok;
        set_op(2, 100, 7);
        bus.req_valid = 4'b0100;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        checks++; if (bus.div_rst_n !== 1'b0) begin errors++; $display("FAIL single_launch_rstn: got %b want 0", bus.div_rst_n); end
        checks++; if (bus.div_divd !== W'(100) || bus.div_dvsr !== W'(7)) begin errors++; $display("FAIL single_operands: got %0d/%0d want 100/7", bus.div_divd, bus.div_dvsr); end
        @(negedge clk);
        checks++; if (bus.div_rst_n !== 1'b1) begin errors++; $display("FAIL single_run_rstn: got %b want 1", bus.div_rst_n); end
        wait_rsp(50, cyc, ok);
        checks++; if (!ok || cyc != LAT + 1) begin errors++; $display("FAIL single_latency: got %0d (seen %0d) want %0d", cyc, ok, LAT + 1); end
        checks++; if (bus.rsp_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", bus.rsp_id); end
        checks++; if (bus.rsp_quo !== W'(14) || bus.rsp_rem !== W'(2)) begin errors++; $display("FAIL single_result: got %0d r %0d want 14 r 2", bus.rsp_quo, bus.rsp_rem); end
        checks++; if ({bus.rsp_dbz, bus.rsp_err} !== 2'b00) begin errors++; $display("FAIL single_flags: got %b want 00", {bus.rsp_dbz, bus.rsp_err}); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_round_robin();
        int td[4] = '{1000, 77, 255, 9};
        int ts[4] = '{10, 5, 16, 4};
        int tq[4] = '{100, 15, 15, 2};
        int tr[4] = '{0, 2, 15, 1};
        int cyc; bit ok; int e;
        apply_reset();
        for (int i = 0; i < 4; i++) set_op(i, td[i], ts[i]);
        bus.req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            e = t % 4;
            wait_rsp(60, cyc, ok);
            checks++; if (!ok || bus.rsp_id !== 2'(e)) begin errors++; $display("FAIL rr_order%0d: got id %0d (seen %0d) want %0d", t, bus.rsp_id, ok, e); end
            checks++; if (bus.rsp_quo !== W'(tq[e]) || bus.rsp_rem !== W'(tr[e])) begin errors++; $display("FAIL rr_result%0d: got %0d r %0d want %0d r %0d", t, bus.rsp_quo, bus.rsp_rem, tq[e], tr[e]); end
        end
        bus.req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_dbz();
        int cyc; bit ok; bit seen_hi;
        apply_reset();
        set_op(1, 50, 0);
        bus.req_valid = 4'b0010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL dbz_ready: got %b want 0010", bus.req_ready); end
        cyc = 0; ok = 1'b0; seen_hi = 1'b0;
        while (cyc < 20 && !ok) begin
            @(negedge clk);
            bus.req_valid = '0;
            cyc++;
            if (bus.div_rst_n === 1'b1) seen_hi = 1'b1;
            if (bus.rsp_valid === 1'b1) ok = 1'b1;
        end
        checks++; if (!ok || cyc != DBZ_LAT) begin errors++; $display("FAIL dbz_latency: got %0d (seen %0d) want %0d", cyc, ok, DBZ_LAT); end
        checks++; if (seen_hi !== DBZ_HI) begin errors++; $display("FAIL dbz_launch: got %b want %b", seen_hi, DBZ_HI); end
        checks++; if ({bus.rsp_dbz, bus.rsp_err} !== 2'b10 || bus.rsp_id !== 2'd1) begin errors++; $display("FAIL dbz_flags: got %b id %0d want 10 id 1", {bus.rsp_dbz, bus.rsp_err}, bus.rsp_id); end
        checks++; if (bus.rsp_quo !== '0 || bus.rsp_rem !== '0) begin errors++; $display("FAIL dbz_result: got %0h r %0h want 0 r 0", bus.rsp_quo, bus.rsp_rem); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int cyc; bit ok;
        apply_reset();
        set_op(3, 200, 9);
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        set_op(0, 1, 1);
        bus.req_valid = 4'b0001;
        wait_rsp(50, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_seen: got no response want response"); end
        for (int i = 0; i < 20; i++) begin
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_quo !== W'(22) || bus.rsp_rem !== W'(2) || {bus.rsp_dbz, bus.rsp_err} !== 2'b00) begin errors++; $display("FAIL bp_stable%0d: got v%b id %0d %0d r %0d want v1 id 3 22 r 2", i, bus.rsp_valid, bus.rsp_id, bus.rsp_quo, bus.rsp_rem); end
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d: got %b want 0000", i, bus.req_ready); end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_complete: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_timeout();
        int cyc; bit ok;
        hang = 1'b1;
        set_op(0, 10, 3);
        bus.req_valid = 4'b0001;
        wait_rsp(TO_CYC + 20, cyc, ok);
        bus.req_valid = '0;
        checks++; if (!ok || cyc != TO_CYC + 2) begin errors++; $display("FAIL to_latency: got %0d (seen %0d) want %0d", cyc, ok, TO_CYC + 2); end
        checks++; if ({bus.rsp_dbz, bus.rsp_err} !== 2'b01 || bus.rsp_id !== 2'd0) begin errors++; $display("FAIL to_flags: got %b id %0d want 01 id 0", {bus.rsp_dbz, bus.rsp_err}, bus.rsp_id); end
        checks++; if (bus.rsp_quo !== '0 || bus.rsp_rem !== '0) begin errors++; $display("FAIL to_result: got %0d r %0d want 0 r 0", bus.rsp_quo, bus.rsp_rem); end
        @(negedge clk);
        hang = 1'b0;
        set_op(1, 12, 5);
        bus.req_valid = 4'b0010;
        wait_rsp(50, cyc, ok);
        bus.req_valid = '0;
        checks++; if (!ok || bus.rsp_id !== 2'd1 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL to_next: got id %0d err %b (seen %0d) want id 1 err 0", bus.rsp_id, bus.rsp_err, ok); end
        checks++; if (bus.rsp_quo !== W'(2) || bus.rsp_rem !== W'(2)) begin errors++; $display("FAIL to_next_result: got %0d r %0d want 2 r 2", bus.rsp_quo, bus.rsp_rem); end
    endtask

    task automatic test_reset_mid_run();
        int cyc; bit ok;
        @(negedge clk);
        set_op(2, 100, 7);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        set_op(3, 30, 4);
        bus.req_valid = 4'b1010;
        rst = 1'b0;
        #1;
        checks++; if ({bus.rsp_valid, bus.rsp_dbz, bus.rsp_err, bus.div_rst_n} !== 4'b0000) begin errors++; $display("FAIL mid_flags: got %b want 0000", {bus.rsp_valid, bus.rsp_dbz, bus.rsp_err, bus.div_rst_n}); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready: got %b want 0000", bus.req_ready); end
        checks++; if (bus.rsp_id !== 2'd0 || bus.rsp_quo !== '0 || bus.rsp_rem !== '0) begin errors++; $display("FAIL mid_rsp: got id %0d %0d r %0d want 0 0 r 0", bus.rsp_id, bus.rsp_quo, bus.rsp_rem); end
        checks++; if (bus.div_divd !== '0 || bus.div_dvsr !== '0) begin errors++; $display("FAIL mid_div: got %0d/%0d want 0/0", bus.div_divd, bus.div_dvsr); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mid_regrant: got %b want 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(50, cyc, ok);
        checks++; if (!ok || bus.rsp_id !== 2'd1 || bus.rsp_quo !== W'(2)) begin errors++; $display("FAIL mid_resp: got id %0d quo %0d (seen %0d) want id 1 quo 2", bus.rsp_id, bus.rsp_quo, ok); end
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_divd  = '0;
        bus.req_dvsr  = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_dbz();
        test_backpressure();
        test_timeout();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
